// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store, one transaction in flight.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [2:0]  d_width,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        m_valid,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic [2:0]  m_width,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [63:0] m_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_IF = 2'd1;
    localparam logic [1:0] WAIT_D  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       sel_d;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    logic [3:0] streak;

    // Fetch wins a contested arbitration once data has taken STREAK_LIMIT grants in a row over it.
    assign sel_d = d_req & ~(if_req & (streak == STREAK_LIMIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak <= 4'd0;
        end else if (d_gnt) begin
            streak <= if_req ? streak + 4'd1 : 4'd0;
        end else if (if_gnt) begin
            streak <= 4'd0;
        end
    end
`else
    assign sel_d = d_req;
`endif

    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_we       = 1'b0;
        m_addr     = 64'd0;
        m_wdata    = 64'd0;
        m_width    = 3'd0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        if_rdata   = 32'd0;
        d_rdata    = 64'd0;
        case (state)
            IDLE: begin
                m_valid = if_req | d_req;
                if (sel_d) begin
                    m_we    = d_we;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                    m_width = d_width;
                    d_gnt   = m_ready;
                    if (m_ready) state_next = WAIT_D;
                end else if (if_req) begin
                    m_addr  = if_addr;
                    m_width = 3'b010;
                    if_gnt  = m_ready;
                    if (m_ready) state_next = WAIT_IF;
                end
            end
            WAIT_IF: begin
                if (m_rvalid) begin
                    if_rvalid  = 1'b1;
                    if_rdata   = m_rdata[31:0];
                    state_next = IDLE;
                end
            end
            WAIT_D: begin
                if (m_rvalid) begin
                    d_rvalid   = 1'b1;
                    d_rdata    = m_rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants/responses, a negedge monitor checks them.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [2:0]  d_width;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [2:0]  m_width;
    logic        m_ready;
    logic        m_rvalid;
    logic [63:0] m_rdata;

    mem_port_arbiter #(.MAX_D_STREAK(2)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_width(m_width), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  width;
    } gnt_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_gnt(input bit is_d, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [2:0] width);
        gnt_t g;
        g.is_d = is_d; g.we = we; g.addr = addr; g.wdata = wdata; g.width = width;
        gq.push_back(g);
    endtask

    task automatic exp_rsp(input bit is_d, input logic [63:0] data);
        rsp_t r;
        r.is_d = is_d; r.data = data;
        rq.push_back(r);
    endtask

    // Monitor: every grant and every response the DUT presents must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (if_gnt || d_gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {62'd0, d_gnt, if_gnt}, 64'd0);
                end else begin
                    gnt_t g;
                    g = gq.pop_front();
                    chk("gnt_d", {63'd0, d_gnt}, {63'd0, g.is_d});
                    chk("gnt_if", {63'd0, if_gnt}, {63'd0, !g.is_d});
                    chk("gnt_m_valid", {63'd0, m_valid}, 64'd1);
                    chk("gnt_m_addr", m_addr, g.addr);
                    chk("gnt_m_we", {63'd0, m_we}, {63'd0, g.we});
                    chk("gnt_m_wdata", m_wdata, g.wdata);
                    chk("gnt_m_width", {61'd0, m_width}, {61'd0, g.width});
                end
            end
            if (if_rvalid || d_rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", {62'd0, d_rvalid, if_rvalid}, 64'd0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_d_rvalid", {63'd0, d_rvalid}, {63'd0, r.is_d});
                    chk("rsp_if_rvalid", {63'd0, if_rvalid}, {63'd0, !r.is_d});
                    if (r.is_d) chk("rsp_d_rdata", d_rdata, r.data);
                    else        chk("rsp_if_rdata", {32'd0, if_rdata}, {32'd0, r.data[31:0]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        if_req   = 1'b0; if_addr = 64'd0;
        d_req    = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0; d_width = 3'd0;
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset state: all outputs 0 even with a stray memory response present.
        @(negedge clock);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_gnts", {62'd0, if_gnt, d_gnt}, 64'd0);
        chk("rst_rvalids", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        chk("rst_m_fields", m_addr | m_wdata | {60'd0, m_we, m_width}, 64'd0);
        chk("rst_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
        tick();
        reset    = 1'b0;
        m_rvalid = 1'b0;
        m_ready  = 1'b1;
        tick();

        // Single fetch, response two cycles after grant.
        if_req = 1'b1; if_addr = 64'h10;
        exp_gnt(0, 0, 64'h10, 64'd0, 3'b010);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        chk("wait_if_m_valid", {63'd0, m_valid}, 64'd0);
        tick();
        m_rvalid = 1'b1; m_rdata = 64'hABCD_0000_0050_0093;
        exp_rsp(0, 64'h0050_0093);
        tick();
        m_rvalid = 1'b0;

        // Contention: data first, fetch in the IDLE cycle after d_rvalid.
        if_req = 1'b1; if_addr = 64'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100; d_width = 3'b011;
        exp_gnt(1, 0, 64'h100, 64'd0, 3'b011);
        tick();
        d_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 64'h1122_3344_5566_7788;
        exp_rsp(1, 64'h1122_3344_5566_7788);
        tick();
        m_rvalid = 1'b0;
        exp_gnt(0, 0, 64'h20, 64'd0, 3'b010);
        tick();
        if_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 64'h13;
        exp_rsp(0, 64'h13);
        tick();
        m_rvalid = 1'b0;

        // Store: fields pass through, ack goes to data only.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hDEAD_BEEF; d_width = 3'b011;
        exp_gnt(1, 1, 64'h200, 64'hDEAD_BEEF, 3'b011);
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wdata = 64'd0;
        m_rvalid = 1'b1; m_rdata = 64'd0;
        exp_rsp(1, 64'd0);
        tick();
        m_rvalid = 1'b0;

        // Backpressure: m_valid held without grant for 3 cycles.
        m_ready = 1'b0;
        d_req = 1'b1; d_addr = 64'h300; d_width = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
            chk("bp_m_addr", m_addr, 64'h300);
            tick();
        end
        m_ready = 1'b1;
        exp_gnt(1, 0, 64'h300, 64'd0, 3'b010);
        tick();
        d_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 64'hCAFE;
        exp_rsp(1, 64'hCAFE);
        tick();

        // m_rvalid in IDLE is ignored.
        m_rdata = 64'h5555;
        @(negedge clock);
        chk("idle_rvalid_ignored", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        chk("idle_rdata_zero", d_rdata | {32'd0, if_rdata}, 64'd0);
        tick();
        m_rvalid = 1'b0;

        // Reset mid-WAIT_D drops the response; next fetch proceeds normally.
        d_req = 1'b1; d_addr = 64'h400; d_width = 3'b011;
        exp_gnt(1, 0, 64'h400, 64'd0, 3'b011);
        tick();
        d_req = 1'b0;
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        m_rvalid = 1'b1; m_rdata = 64'h7777;
        @(negedge clock);
        chk("late_rvalid_dropped", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        tick();
        m_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 64'h500;
        exp_gnt(0, 0, 64'h500, 64'd0, 3'b010);
        tick();
        if_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 64'h0010_0073;
        exp_rsp(0, 64'h0010_0073);
        tick();
        m_rvalid = 1'b0;

        // Both requesters held continuously for six transactions.
        begin
            bit order[6];
`ifdef ARB_STARVE_GUARD_EN
            order = '{1, 1, 0, 1, 1, 0};
`else
            order = '{1, 1, 1, 1, 1, 1};
`endif
            if_req = 1'b1; if_addr = 64'h600;
            d_req = 1'b1; d_we = 1'b0; d_addr = 64'h700; d_width = 3'b011;
            for (int k = 0; k < 6; k++) begin
                if (order[k]) exp_gnt(1, 0, 64'h700, 64'd0, 3'b011);
                else          exp_gnt(0, 0, 64'h600, 64'd0, 3'b010);
                tick();
                m_rvalid = 1'b1; m_rdata = 64'h1000 + 64'(k);
                exp_rsp(order[k], 64'h1000 + 64'(k));
                tick();
                m_rvalid = 1'b0;
            end
            if_req = 1'b0; d_req = 1'b0;
        end
        tick();

        @(negedge clock);
        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
